// File: rtl/det_log_pkg.sv
// Shared defaults and helpers for the detection event logger.
package det_log_pkg;

    localparam int POS_W_DEF = 16;
    localparam int CNT_W_DEF = 16;
    localparam int DEPTH_DEF = 8;

    // Pointer width for a FIFO of the given depth; never narrower than one bit.
    function automatic int ptrWidth(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/det_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module det_fifo
    import det_log_pkg::*;
#(
    parameter int WIDTH = POS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = ptrWidth(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [CW-1:0]    count;
    logic             doPush;
    logic             doPop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop && !empty && !clear;
    assign doPush = push && (!full || doPop) && !clear;

    // Head is forced to zero while empty so the output is defined straight out of reset.
    assign head = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= push_data;
    end

endmodule

// File: rtl/det_event_logger.sv
// Tracks serial bit positions, queues the position of each detection and keeps hit/overflow status.
module det_event_logger
    import det_log_pkg::*;
#(
    parameter int POS_W = POS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             sof,
    input  logic             det,
    input  logic             clear,
    output logic             evt_valid,
    output logic [POS_W-1:0] evt_pos,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] curPos;
    logic             hitNow;
    logic             popNow;
    logic             fifoFull;
    logic             fifoEmpty;

    assign curPos    = sof ? '0 : pos;
    assign hitNow    = bit_en && det;
    assign evt_valid = !fifoEmpty;
    assign popNow    = evt_valid && evt_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       pos <= '0;
        else if (clear)  pos <= '0;
        else if (bit_en) pos <= curPos + 1'b1;
    end

    // Every hit counts, including ones the full FIFO has to drop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                             hit_count <= '0;
        else if (clear)                        hit_count <= '0;
        else if (hitNow && hit_count != CNT_MAX) hit_count <= hit_count + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                              overflow <= 1'b0;
        else if (clear)                         overflow <= 1'b0;
        else if (hitNow && fifoFull && !popNow) overflow <= 1'b1;
    end

    det_fifo #(
        .WIDTH (POS_W),
        .DEPTH (DEPTH)
    ) eventFifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .push      (hitNow),
        .push_data (curPos),
        .pop       (popNow),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .head      (evt_pos)
    );

endmodule
